cfg_bus_master: RTL and testbench



---
 rtl/cfg_bus_pkg.sv | 35 +++
 rtl/cfg_bus_master_byte_ser.sv | 62 ++++++
 rtl/cfg_bus_master.sv | 239 +++++++++++++++++++++++
 tb/tb_cfg_bus_master.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_bus_pkg.sv
// Shared constants, FSM state encoding and helpers for the config-bus master.
package cfg_bus_pkg;

  localparam logic [7:0] CMD_WR   = 8'hA5;
  localparam logic [7:0] CMD_RD   = 8'h5A;
  localparam logic [7:0] RSP_WACK = 8'hAC;
  localparam logic [7:0] RSP_OK   = 8'h00;
  localparam logic [7:0] RSP_TMO  = 8'hEE;

  // Width of the per-field byte counters (supports fields up to 255 bytes).
  localparam int CNT_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ADDR   = 4'd1,
    ST_WDATA  = 4'd2,
    ST_WRITE  = 4'd3,
    ST_WACK   = 4'd4,
    ST_RDREQ  = 4'd5,
    ST_RDWAIT = 4'd6,
    ST_RSTAT  = 4'd7,
    ST_RDATA  = 4'd8
  } state_e;

  // States in which the parser accepts host bytes.
  function automatic logic is_rx_state(input state_e s);
    logic r;
    case (s)
      ST_IDLE, ST_ADDR, ST_WDATA: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cfg_bus_master_byte_ser.sv
// Word-to-byte serializer: loads a word and emits it MSB byte first over
// valid/ready, pulsing done on the handshake of the final byte.
module cfg_byte_ser
  import cfg_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] word,
  output logic                  tx_vld,
  output logic [7:0]            tx_data,
  input  logic                  tx_rdy,
  output logic                  done
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  vld_q, vld_d;

  // Load a new word, or shift out one byte per completed handshake.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    vld_d  = vld_q;
    if (load) begin
      word_d = word;
      cnt_d  = CNT_W'(NB - 1);
      vld_d  = 1'b1;
    end else if (vld_q && tx_rdy) begin
      word_d = word_q << 8;
      if (cnt_q == CNT_W'(0)) begin
        vld_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      vld_d = vld_q;
    end
  end

  // Serializer state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      word_q <= '0;
      cnt_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
    end
  end

  assign tx_vld  = vld_q;
  assign tx_data = word_q[DATA_WIDTH-1 -: 8];
  assign done    = vld_q & tx_rdy & (cnt_q == CNT_W'(0));

endmodule

// File: rtl/cfg_bus_master.sv
// Host byte-stream command parser driving the config write bus and the
// read-back request bus, answering with an ack byte or status plus data.
module cfg_bus_master
  import cfg_bus_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 32,
  parameter int REG_DATA_WIDTH = 32,
  parameter int RD_TIMEOUT     = 256
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      rx_vld,
  input  logic [7:0]                rx_data,
  output logic                      rx_rdy,
  output logic                      tx_vld,
  output logic [7:0]                tx_data,
  input  logic                      tx_rdy,
  output logic                      cfg_vld,
  output logic [REG_ADDR_WIDTH-1:0] cfg_addr,
  output logic [REG_DATA_WIDTH-1:0] cfg_data,
  output logic                      rd_req,
  input  logic                      rd_vld,
  input  logic [REG_DATA_WIDTH-1:0] rd_data,
  output logic                      err
);

  localparam int NA   = REG_ADDR_WIDTH / 8;
  localparam int ND   = REG_DATA_WIDTH / 8;
  localparam int TW   = $clog2(RD_TIMEOUT + 1);

  state_e                    state_q, state_d;
  logic                      op_wr_q, op_wr_d;
  logic [CNT_W-1:0]          byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]             tmo_cnt_q, tmo_cnt_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REG_DATA_WIDTH-1:0] data_q, data_d;
  logic [REG_DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic [7:0]                status_q, status_d;
  logic                      err_q, err_d;
  logic                      rx_rdy_q, rx_rdy_d;
  logic                      tx_vld_q, tx_vld_d;
  logic [7:0]                tx_data_q, tx_data_d;
  logic                      cfg_vld_q, cfg_vld_d;
  logic                      rd_req_q, rd_req_d;

  logic       rx_fire;
  logic       tx_fire;
  logic       ser_load;
  logic       ser_vld;
  logic [7:0] ser_data;
  logic       ser_done;

  assign rx_fire = rx_vld & rx_rdy_q;
  assign tx_fire = tx_vld_q & tx_rdy;

  // Next-state and datapath: frame parsing, read wait/timeout, responses.
  always_comb begin
    state_d    = state_q;
    op_wr_d    = op_wr_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rdat_d     = rdat_q;
    status_d   = status_q;
    err_d      = 1'b0;
    ser_load   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          byte_cnt_d = '0;
          if (rx_data == CMD_WR) begin
            op_wr_d = 1'b1;
            state_d = ST_ADDR;
          end else if (rx_data == CMD_RD) begin
            op_wr_d = 1'b0;
            state_d = ST_ADDR;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (rx_fire) begin
          addr_d = (addr_q << 8) | REG_ADDR_WIDTH'(rx_data);
          if (byte_cnt_q == CNT_W'(NA - 1)) begin
            byte_cnt_d = '0;
            state_d    = op_wr_q ? ST_WDATA : ST_RDREQ;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_WDATA: begin
        if (rx_fire) begin
          data_d = (data_q << 8) | REG_DATA_WIDTH'(rx_data);
          if (byte_cnt_q == CNT_W'(ND - 1)) begin
            byte_cnt_d = '0;
            state_d    = ST_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_WDATA;
        end
      end
      ST_WRITE: state_d = ST_WACK;
      ST_WACK: begin
        if (tx_fire) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WACK;
        end
      end
      ST_RDREQ: begin
        tmo_cnt_d = '0;
        state_d   = ST_RDWAIT;
      end
      ST_RDWAIT: begin
        // rd_vld wins even on the cycle the timeout limit is reached.
        if (rd_vld) begin
          rdat_d   = rd_data;
          status_d = RSP_OK;
          state_d  = ST_RSTAT;
        end else if (tmo_cnt_q == TW'(RD_TIMEOUT - 1)) begin
          err_d    = 1'b1;
          status_d = RSP_TMO;
          state_d  = ST_RSTAT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      ST_RSTAT: begin
        if (tx_fire) begin
          if (status_q == RSP_OK) begin
            ser_load = 1'b1;
            state_d  = ST_RDATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_RSTAT;
        end
      end
      ST_RDATA: begin
        if (ser_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RDATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    rx_rdy_d  = is_rx_state(state_d);
    cfg_vld_d = (state_d == ST_WRITE);
    rd_req_d  = (state_d == ST_RDREQ);
    case (state_d)
      ST_WACK: begin
        tx_vld_d  = 1'b1;
        tx_data_d = RSP_WACK;
      end
      ST_RSTAT: begin
        tx_vld_d  = 1'b1;
        tx_data_d = status_d;
      end
      default: begin
        tx_vld_d  = 1'b0;
        tx_data_d = 8'h00;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      op_wr_q    <= 1'b0;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rdat_q     <= '0;
      status_q   <= 8'h00;
      err_q      <= 1'b0;
      rx_rdy_q   <= 1'b0;
      tx_vld_q   <= 1'b0;
      tx_data_q  <= 8'h00;
      cfg_vld_q  <= 1'b0;
      rd_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_wr_q    <= op_wr_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rdat_q     <= rdat_d;
      status_q   <= status_d;
      err_q      <= err_d;
      rx_rdy_q   <= rx_rdy_d;
      tx_vld_q   <= tx_vld_d;
      tx_data_q  <= tx_data_d;
      cfg_vld_q  <= cfg_vld_d;
      rd_req_q   <= rd_req_d;
    end
  end

  cfg_byte_ser #(
    .DATA_WIDTH(REG_DATA_WIDTH)
  ) u_ser (
    .clk    (clk),
    .rstn   (rstn),
    .load   (ser_load),
    .word   (rdat_q),
    .tx_vld (ser_vld),
    .tx_data(ser_data),
    .tx_rdy (tx_rdy),
    .done   (ser_done)
  );

  // The ack/status flops and the serializer are never valid together.
  assign tx_vld   = tx_vld_q | ser_vld;
  assign tx_data  = ser_vld ? ser_data : tx_data_q;
  assign rx_rdy   = rx_rdy_q;
  assign cfg_vld  = cfg_vld_q;
  assign cfg_addr = addr_q;
  assign cfg_data = data_q;
  assign rd_req   = rd_req_q;
  assign err      = err_q;

endmodule

// File: tb/tb_cfg_bus_master.sv
// Self-checking bench for cfg_bus_master: table of frames plus hand-written
// corner sequences, with a scoreboard of expected writes, reads and tx bytes.
module tb_cfg_bus_master;

  localparam int RD_TO = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_vld = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rdy;
  logic        tx_vld;
  logic [7:0]  tx_data;
  logic        tx_rdy = 1'b1;
  logic        cfg_vld;
  logic [31:0] cfg_addr;
  logic [31:0] cfg_data;
  logic        rd_req;
  logic        rd_vld = 1'b0;
  logic [31:0] rd_data = 32'h0;
  logic        err;

  cfg_bus_master #(
    .REG_ADDR_WIDTH(32),
    .REG_DATA_WIDTH(32),
    .RD_TIMEOUT    (RD_TO)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rx_vld  (rx_vld),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy),
    .tx_vld  (tx_vld),
    .tx_data (tx_data),
    .tx_rdy  (tx_rdy),
    .cfg_vld (cfg_vld),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .rd_req  (rd_req),
    .rd_vld  (rd_vld),
    .rd_data (rd_data),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          delay;
    bit          rnd;
    logic [7:0]  exp_status;
    int          exp_err;
  } vec_t;

  vec_t vecs[8];

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int last_rx_cyc = 0;
  int rdreq_cyc   = 0;
  int err_cyc     = 0;
  int err_seen    = 0;
  bit rnd_mode    = 1'b0;
  int resp_delay  = 0;
  logic [31:0] resp_data = 32'h0;

  logic [7:0]  tx_q[$];
  logic [63:0] wr_q[$];
  logic [31:0] rd_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1 tx_rdy = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Read responder: answers rd_req with rd_vld resp_delay cycles later.
  initial forever begin
    @(negedge clk);
    if (rd_req === 1'b1 && resp_delay > 0) begin
      repeat (resp_delay - 1) @(posedge clk);
      @(posedge clk);
      #1;
      rd_vld  = 1'b1;
      rd_data = resp_data;
      @(posedge clk);
      #1;
      rd_vld  = 1'b0;
      rd_data = 32'h0;
    end
  end

  // Monitor and scoreboard.
  initial begin
    logic [63:0] w;
    logic [31:0] a;
    logic [7:0]  b;
    bit          prev_stall;
    logic [7:0]  prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (prev_stall) begin
          check("tx_stall_hold", {tx_vld, tx_data}, {1'b1, prev_data});
        end
        prev_stall = (tx_vld === 1'b1) && (tx_rdy === 1'b0);
        prev_data  = tx_data;
        if (cfg_vld === 1'b1) begin
          if (wr_q.size() == 0) begin
            check("cfg_vld_unexpected", 64'(cfg_vld), 64'd0);
          end else begin
            w = wr_q.pop_front();
            check("cfg_addr", 64'(cfg_addr), 64'(w[63:32]));
            check("cfg_data", 64'(cfg_data), 64'(w[31:0]));
            check("cfg_vld_latency", 64'(cyc), 64'(last_rx_cyc + 1));
          end
        end
        if (rd_req === 1'b1) begin
          rdreq_cyc = cyc;
          if (rd_q.size() == 0) begin
            check("rd_req_unexpected", 64'(rd_req), 64'd0);
          end else begin
            a = rd_q.pop_front();
            check("rd_req_addr", 64'(cfg_addr), 64'(a));
          end
        end
        if (tx_vld === 1'b1 && tx_rdy === 1'b1) begin
          if (tx_q.size() == 0) begin
            check("tx_unexpected", 64'(tx_vld), 64'd0);
          end else begin
            b = tx_q.pop_front();
            check("tx_byte", 64'(tx_data), 64'(b));
          end
        end
        if (err === 1'b1) begin
          err_seen++;
          err_cyc = cyc;
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] bt, input int gap);
    int  k;
    bit  done;
    k    = 0;
    done = 1'b0;
    rx_vld = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_vld  = 1'b1;
    rx_data = bt;
    while (!done && k < 200) begin
      @(negedge clk);
      if (rx_rdy === 1'b1) begin
        last_rx_cyc = cyc;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      k++;
    end
    rx_vld = 1'b0;
    if (!done) begin
      check("rx_accept_timeout", 64'(rx_rdy), 64'd1);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (tx_q.size() == 0 && wr_q.size() == 0 && rd_q.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      check("response_timeout", 64'(tx_q.size() + wr_q.size() + rd_q.size()), 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int          e0;
    logic [31:0] x;
    e0 = err_seen;
    rnd_mode   = v.rnd;
    resp_delay = v.delay;
    resp_data  = v.data;
    tx_q.push_back(v.exp_status);
    if (v.is_wr) begin
      wr_q.push_back({v.addr, v.data});
    end else begin
      rd_q.push_back(v.addr);
      if (v.exp_status == 8'h00) begin
        x = v.data;
        for (int i = 0; i < 4; i++) tx_q.push_back(x[31 - 8*i -: 8]);
      end
    end
    send_byte(v.is_wr ? 8'hA5 : 8'h5A, v.rnd ? int'($urandom_range(0, 2)) : 0);
    x = v.addr;
    for (int i = 0; i < 4; i++) send_byte(x[31 - 8*i -: 8], v.rnd ? int'($urandom_range(0, 2)) : 0);
    if (v.is_wr) begin
      x = v.data;
      for (int i = 0; i < 4; i++) send_byte(x[31 - 8*i -: 8], v.rnd ? int'($urandom_range(0, 2)) : 0);
    end
    wait_idle();
    check("err_count", 64'(err_seen - e0), 64'(v.exp_err));
    if (v.exp_err != 0) begin
      check("timeout_err_cycle", 64'(err_cyc), 64'(rdreq_cyc + RD_TO + 1));
    end
    rnd_mode   = 1'b0;
    resp_delay = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t post;
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, 8'hAC, 0};
    vecs[1] = '{1'b0, 32'h0000_0020, 32'h1234_5678, 3, 1'b0, 8'h00, 0};
    vecs[2] = '{1'b0, 32'h0000_0030, 32'h5555_AAAA, 0, 1'b0, 8'hEE, 1};
    vecs[3] = '{1'b1, 32'h0000_0040, 32'hCAFE_F00D, 0, 1'b0, 8'hAC, 0};
    vecs[4] = '{1'b0, 32'h0000_0044, 32'hA1B2_C3D4, RD_TO, 1'b0, 8'h00, 0};
    vecs[5] = '{1'b0, 32'h0000_0048, 32'h8070_6050, 1, 1'b0, 8'h00, 0};
    vecs[6] = '{1'b0, 32'h0000_004C, 32'h0F1E_2D3C, 2, 1'b1, 8'h00, 0};
    vecs[7] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 0, 1'b1, 8'hAC, 0};

    // Reset state.
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {rx_rdy, tx_vld, tx_data, cfg_vld, cfg_addr, cfg_data, rd_req, err}, 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Bad command byte: one-cycle err, parser stays ready.
    send_byte(8'h33, 0);
    @(negedge clk);
    check("bad_cmd_err", {err, rx_rdy, cfg_vld, rd_req}, {1'b1, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    check("bad_cmd_err_pulse", {err, rx_rdy}, {1'b0, 1'b1});
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Late rd_vld while idle is ignored.
    rd_vld  = 1'b1;
    rd_data = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    rd_vld  = 1'b0;
    rd_data = 32'h0;
    repeat (3) begin
      @(negedge clk);
      check("idle_rd_vld_ignored", {tx_vld, err, rx_rdy}, {1'b0, 1'b0, 1'b1});
    end
    @(posedge clk);
    #1;

    // Reset after three address bytes discards the partial frame.
    send_byte(8'hA5, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midframe_reset_outputs", {rx_rdy, tx_vld, tx_data, cfg_vld, cfg_addr, cfg_data, rd_req, err}, 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    post = '{1'b1, 32'h0000_0080, 32'h0BAD_F00D, 0, 1'b0, 8'hAC, 0};
    run_vec(post);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 64'(tx_q.size() + wr_q.size() + rd_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
